switching_gen_sequencer: RTL and testbench

SWITCHING_GEN_SEQUENCER -- requirements
Module: switching_gen_sequencer

---
 rtl/switching_gen_sequencer_pkg.sv | 21 ++
 rtl/switching_gen_sequencer_ks_byte_fifo.sv | 55 +++++
 rtl/switching_gen_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_switching_gen_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/switching_gen_sequencer_pkg.sv
// Shared types and helpers for the switching-generator sequencer:
// FSM state encoding and the seed-word count calculation.
package switching_gen_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SET,
      ST_WAIT,
      ST_RUN,
      ST_FLUSH,
      ST_DONE,
      ST_ERR
   } state_t;

   // Number of seed words needed to cover seed_bits, rounding up.
   function automatic int calc_seed_words(input int seed_bits, input int word_bits);
      return (seed_bits + word_bits - 1) / word_bits;
   endfunction

endpackage

// File: rtl/switching_gen_sequencer_ks_byte_fifo.sv
// Two-entry keystream byte FIFO: valid/ready pop side, push side guarded
// by a full flag; a push into a full FIFO succeeds when a pop happens too.
module ks_byte_fifo (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_flush,
   input  logic       i_push,
   input  logic [7:0] i_data,
   input  logic       i_ready,
   output logic       o_full,
   output logic       o_valid,
   output logic [7:0] o_data
);

   logic [7:0] r_mem [2];
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;
   logic       w_pop;
   logic       w_push;

   assign o_valid = (r_count != 2'd0);
   assign o_full  = (r_count == 2'd2);
   assign o_data  = o_valid ? r_mem[r_rd_ptr] : 8'h00;
   assign w_pop   = o_valid & i_ready;
   assign w_push  = i_push & (~o_full | w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= 8'h00;
         r_mem[1] <= 8'h00;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_flush) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/switching_gen_sequencer.sv
// Loads a seed into a switching keystream generator, strobes it, then
// packs the generator's output bits MSB-first into bytes for a consumer.
module switching_gen_sequencer
   import switching_gen_sequencer_pkg::*;
#(
   parameter int N       = 8,
   parameter int M       = 4,
   parameter int W       = 8,
   parameter int LEN_W   = 16,
   parameter int GEN_LAT = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [LEN_W-1:0]   nbits,
   input  logic [W-1:0]       seed_data,
   input  logic               seed_valid,
   output logic               seed_ready,
   output logic [N+3*M-1:0]   gen_seed,
   output logic               gen_set,
   input  logic               gen_out,
   output logic [7:0]         ks_data,
   output logic               ks_valid,
   input  logic               ks_ready,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int SEED_W = N + 3 * M;
   localparam int K      = calc_seed_words(SEED_W, W);
   localparam int KW     = $clog2(K + 1);

   state_t            r_state;
   state_t            w_state_next;
   logic [SEED_W-1:0] r_gen_seed;
   logic [SEED_W-1:0] w_seed_next;
   logic [KW-1:0]     r_word_cnt;
   logic [15:0]       r_wait;
   logic [LEN_W-1:0]  r_remain;
   logic [7:0]        r_shift;
   logic [2:0]        r_pos;
   logic              r_err;
   logic [7:0]        w_packed;
   logic              w_byte_done;
   logic              w_last;
   logic              w_can_push;
   logic              w_run_push;
   logic              w_flush_push;
   logic              w_overrun;
   logic              w_push;
   logic [7:0]        w_push_data;
   logic              w_fifo_full;
   logic              w_fifo_flush;

   // Word i fills seed bits i*W.. with its MSB landing on the lowest index.
   genvar gi;
   generate
      for (gi = 0; gi < SEED_W; gi++) begin : g_seed
         assign w_seed_next[gi] = (r_word_cnt == KW'(gi / W)) ? seed_data[W-1-(gi % W)]
                                                              : r_gen_seed[gi];
      end
   endgenerate

   always_comb begin
      w_packed                 = r_shift;
      w_packed[3'd7 - r_pos]   = gen_out;
   end

   assign w_byte_done  = (r_pos == 3'd7);
   assign w_last       = (r_remain == LEN_W'(1));
   assign w_can_push   = ~w_fifo_full | (ks_valid & ks_ready);
   assign w_run_push   = (r_state == ST_RUN) & w_byte_done & w_can_push;
   assign w_overrun    = (r_state == ST_RUN) & w_byte_done & ~w_can_push;
   assign w_flush_push = (r_state == ST_FLUSH) & (r_pos != 3'd0) & w_can_push;
   assign w_push       = w_run_push | w_flush_push;
   assign w_push_data  = (r_state == ST_RUN) ? w_packed : r_shift;
   assign w_fifo_flush = (r_state == ST_ERR) & start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE, ST_ERR: begin
            if (start) begin
               w_state_next = (nbits != '0) ? ST_LOAD : ST_DONE;
            end
         end
         ST_LOAD: begin
            if (seed_valid && (r_word_cnt == KW'(K - 1))) begin
               w_state_next = ST_SET;
            end
         end
         ST_SET:   w_state_next = (GEN_LAT == 1) ? ST_RUN : ST_WAIT;
         ST_WAIT: begin
            if (r_wait == 16'(GEN_LAT - 2)) begin
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_overrun) begin
               w_state_next = ST_ERR;
            end else if (w_last) begin
               w_state_next = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if ((r_pos == 3'd0) && !ks_valid) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE:  w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      seed_ready = (r_state == ST_LOAD);
      gen_set    = (r_state == ST_SET);
      busy       = (r_state != ST_IDLE);
      done       = (r_state == ST_DONE);
      err        = r_err;
      gen_seed   = r_gen_seed;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gen_seed <= '0;
         r_word_cnt <= '0;
         r_wait     <= '0;
         r_remain   <= '0;
         r_shift    <= '0;
         r_pos      <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_ERR: begin
               if (start) begin
                  r_remain   <= nbits;
                  r_word_cnt <= '0;
                  r_shift    <= '0;
                  r_pos      <= '0;
               end
            end
            ST_LOAD: begin
               if (seed_valid) begin
                  r_gen_seed <= w_seed_next;
                  r_word_cnt <= r_word_cnt + KW'(1);
               end
            end
            ST_SET:  r_wait <= '0;
            ST_WAIT: r_wait <= r_wait + 16'd1;
            ST_RUN: begin
               // A completed byte leaves the packer whether pushed or dropped.
               r_remain <= r_remain - LEN_W'(1);
               r_pos    <= r_pos + 3'd1;
               r_shift  <= w_byte_done ? 8'h00 : w_packed;
            end
            ST_FLUSH: begin
               if (w_flush_push) begin
                  r_shift <= '0;
                  r_pos   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_overrun) begin
         r_err <= 1'b1;
      end else if (w_fifo_flush) begin
         r_err <= 1'b0;
      end
   end

   ks_byte_fifo u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (w_fifo_flush),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_ready (ks_ready),
      .o_full  (w_fifo_full),
      .o_valid (ks_valid),
      .o_data  (ks_data)
   );

endmodule

// File: tb/tb_switching_gen_sequencer.sv
// Directed bench for switching_gen_sequencer (N=4, M=3, W=8, GEN_LAT=1):
// expected bytes are queued at stimulus time and checked by a monitor.
module tb_switching_gen_sequencer;

   localparam int N       = 4;
   localparam int M       = 3;
   localparam int W       = 8;
   localparam int LEN_W   = 16;
   localparam int GEN_LAT = 1;
   localparam logic [12:0] EXP_SEED = 13'b1110010100101;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [LEN_W-1:0] nbits = '0;
   logic [W-1:0]     seed_data = '0;
   logic             seed_valid = 1'b0;
   logic             seed_ready;
   logic [12:0]      gen_seed;
   logic             gen_set;
   logic             gen_out = 1'b0;
   logic [7:0]       ks_data;
   logic             ks_valid;
   logic             ks_ready = 1'b0;
   logic             busy;
   logic             done;
   logic             err;

   int               checks = 0;
   int               errors = 0;
   logic [7:0]       sb[$];

   always #5 clk = ~clk;

   switching_gen_sequencer #(
      .N(N), .M(M), .W(W), .LEN_W(LEN_W), .GEN_LAT(GEN_LAT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .nbits      (nbits),
      .seed_data  (seed_data),
      .seed_valid (seed_valid),
      .seed_ready (seed_ready),
      .gen_seed   (gen_seed),
      .gen_set    (gen_set),
      .gen_out    (gen_out),
      .ks_data    (ks_data),
      .ks_valid   (ks_valid),
      .ks_ready   (ks_ready),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   // Monitor: every accepted byte must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && ks_valid && ks_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL ks_byte: got %02h, required none (queue empty)", ks_data);
         end else begin
            logic [7:0] exp_b;
            exp_b = sb.pop_front();
            if (ks_data !== exp_b) begin
               errors++;
               $display("FAIL ks_byte: got %02h, required %02h", ks_data, exp_b);
            end else begin
               $display("byte accepted: %02h", ks_data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end else begin
         $display("check %s: %0h", name, act);
      end
   endtask

   // Start a run, load seed A5/3C, then feed bits MSB-first from 'bits'.
   // ks_ready rises at bit index ready_bit (negative: high from the start).
   task automatic run_seq(input logic [LEN_W-1:0] nb, input logic [31:0] bits,
                          input int n_feed, input int ready_bit);
      if (ready_bit < 0) ks_ready = 1'b1;
      start = 1'b1;
      nbits = nb;
      tick();
      start = 1'b0;
      seed_valid = 1'b1;
      seed_data  = 8'hA5;
      chk("seed_ready_w0", {31'd0, seed_ready}, 32'd1);
      tick();
      seed_data = 8'h3C;
      chk("seed_ready_w1", {31'd0, seed_ready}, 32'd1);
      tick();
      seed_valid = 1'b0;
      chk("gen_set_pulse", {31'd0, gen_set}, 32'd1);
      chk("gen_seed", {19'd0, gen_seed}, {19'd0, EXP_SEED});
      gen_out = ~bits[31];
      tick();
      chk("gen_set_clear", {31'd0, gen_set}, 32'd0);
      for (int i = 0; i < n_feed; i++) begin
         gen_out = bits[31-i];
         if (i == ready_bit) ks_ready = 1'b1;
         tick();
      end
   endtask

   task automatic wait_done();
      for (int c = 0; c < 40; c++) begin
         if (done) break;
         tick();
      end
      chk("done_pulse", {31'd0, done}, 32'd1);
      tick();
      chk("done_clear", {31'd0, done}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #2;
      chk("rst_ctrl", {26'd0, seed_ready, gen_set, ks_valid, busy, done, err}, 32'd0);
      chk("rst_data", {11'd0, ks_data, gen_seed}, 32'd0);
      #20;
      rst_n = 1'b1;
      tick();

      // Two full bytes, consumer always ready
      sb.push_back(8'hB2);
      sb.push_back(8'hFF);
      run_seq(16'd16, 32'hB2FF_0000, 16, -1);
      wait_done();

      // Partial byte padded with zeros
      sb.push_back(8'hE0);
      run_seq(16'd3, 32'hE000_0000, 3, -1);
      wait_done();

      // Zero-length run: straight to DONE with no seed handshake
      start = 1'b1;
      nbits = 16'd0;
      tick();
      start = 1'b0;
      chk("zero_done", {31'd0, done}, 32'd1);
      chk("zero_no_seed", {30'd0, seed_ready, gen_set}, 32'd0);
      tick();
      chk("zero_idle", {30'd0, busy, done}, 32'd0);

      // Third byte completes while the consumer pops: push+pop on full FIFO
      ks_ready = 1'b0;
      sb.push_back(8'hC3);
      sb.push_back(8'h5A);
      sb.push_back(8'h96);
      run_seq(16'd24, 32'hC35A_9600, 24, 23);
      chk("full_pushpop_err", {31'd0, err}, 32'd0);
      wait_done();

      // Overrun: consumer stalled, third byte is dropped
      ks_ready = 1'b0;
      sb.push_back(8'h12);
      sb.push_back(8'h34);
      run_seq(16'd24, 32'h1234_5600, 24, 1000);
      chk("ovr_err", {31'd0, err}, 32'd1);
      chk("ovr_busy", {31'd0, busy}, 32'd1);
      chk("ovr_head", {24'd0, ks_data}, 32'h12);
      tick();
      chk("ovr_hold", {23'd0, ks_valid, ks_data}, 32'h112);
      ks_ready = 1'b1;
      tick();
      ks_ready = 1'b0;
      chk("ovr_second", {24'd0, ks_data}, 32'h34);
      sb.delete();
      start = 1'b1;
      nbits = 16'd0;
      tick();
      start = 1'b0;
      chk("err_restart_done", {31'd0, done}, 32'd1);
      chk("err_cleared", {30'd0, err, ks_valid}, 32'd0);
      tick();
      chk("err_restart_idle", {31'd0, busy}, 32'd0);

      // Asynchronous reset in the middle of RUN
      run_seq(16'd16, 32'hF000_0000, 4, -1);
      rst_n = 1'b0;
      #1;
      chk("midrun_rst_ctrl", {26'd0, seed_ready, gen_set, ks_valid, busy, done, err}, 32'd0);
      chk("midrun_rst_data", {11'd0, ks_data, gen_seed}, 32'd0);
      #2;
      rst_n = 1'b1;
      tick();
      chk("post_rst_busy", {31'd0, busy}, 32'd0);

      sb.push_back(8'hE0);
      run_seq(16'd3, 32'hE000_0000, 3, -1);
      wait_done();

      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog");
   end

endmodule
